seg7_decode: RTL and testbench



---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_lut.sv | 36 +++
 rtl/seg7_decode.sv | 88 ++++++++
 tb/tb_seg7_decode.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment read-back decoder: active-low pattern
// constants (bit6=g .. bit0=a), FSM state type and decoded token struct.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        TRACK = 1'b0,
        EMIT  = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] bcd;
        logic       blank;
        logic       err;
    } token_t;

endpackage

// File: rtl/seg7_lut.sv
// Combinational pattern -> token decode. Hex letters A..F decode to 10..15
// only when SEG7_DECODE_HEX_EN is defined; otherwise they are errors.
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output token_t     token_o
);

    always_comb begin
        token_o = '{bcd: 4'd0, blank: 1'b0, err: 1'b0};
        case (pattern_i)
            SEG_0:     token_o.bcd = 4'd0;
            SEG_1:     token_o.bcd = 4'd1;
            SEG_2:     token_o.bcd = 4'd2;
            SEG_3:     token_o.bcd = 4'd3;
            SEG_4:     token_o.bcd = 4'd4;
            SEG_5:     token_o.bcd = 4'd5;
            SEG_6:     token_o.bcd = 4'd6;
            SEG_7:     token_o.bcd = 4'd7;
            SEG_8:     token_o.bcd = 4'd8;
            SEG_9:     token_o.bcd = 4'd9;
            SEG_BLANK: token_o.blank = 1'b1;
`ifdef SEG7_DECODE_HEX_EN
            SEG_A:     token_o.bcd = 4'd10;
            SEG_B:     token_o.bcd = 4'd11;
            SEG_C:     token_o.bcd = 4'd12;
            SEG_D:     token_o.bcd = 4'd13;
            SEG_E:     token_o.bcd = 4'd14;
            SEG_F:     token_o.bcd = 4'd15;
`endif
            default:   token_o.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_decode.sv
// Samples an active-low 7-segment pattern, waits for it to be stable, and
// emits one decoded token per displayed change (optional: SEG7_DECODE_HEX_EN).
module seg7_decode
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] leds,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] bcd,
    output logic       blank,
    output logic       err,
    output state_e     dbg_state
);

    // Handshake: a token transfers on a rising edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, bcd/blank/err are held.

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [6:0]    samp_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    last_q;
    logic          last_vld_q;
    token_t        tok_q;
    token_t        dec;
    logic          match, at_max, fire;

    seg7_lut u_lut (
        .pattern_i (samp_q),
        .token_o   (dec)
    );

    assign match  = (leds == samp_q);
    assign at_max = (cnt_q == CNT_MAX);
    assign fire   = match && at_max && (!last_vld_q || (samp_q != last_q));

    // Counting is frozen at zero while a token waits, so tracking restarts on return.
    always_comb begin
        cnt_d = '0;
        if (state_q == TRACK && match) begin
            cnt_d = at_max ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TRACK:   if (fire) state_d = EMIT;
            EMIT:    if (out_ready) state_d = TRACK;
            default: state_d = TRACK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TRACK;
            samp_q     <= SEG_BLANK;
            cnt_q      <= '0;
            last_q     <= SEG_BLANK;
            last_vld_q <= 1'b0;
            tok_q      <= '{bcd: 4'd0, blank: 1'b0, err: 1'b0};
        end else begin
            state_q <= state_d;
            samp_q  <= leds;
            cnt_q   <= cnt_d;
            if (state_q == TRACK && fire) begin
                tok_q      <= dec;
                last_q     <= samp_q;
                last_vld_q <= 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = (state_q == EMIT);
        bcd       = tok_q.bcd;
        blank     = tok_q.blank;
        err       = tok_q.err;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_seg7_decode.sv
// Randomized and directed bench for seg7_decode against a window-based
// reference model of the stability, duplicate and handshake rules.
module tb_seg7_decode;
    import seg7_pkg::*;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] leds = 7'h7F;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] bcd;
    logic       blank;
    logic       err;
    state_e     dbg_state;

    seg7_decode #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .leds      (leds),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .bcd       (bcd),
        .blank     (blank),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [5:0] exp_q[$];
    logic [6:0] pat_tab [16];

    // Reference model: leds seen at the most recent edges and the number of
    // edges since the window last restarted (reset or transfer).
    logic [6:0] m_hist[$];
    int         m_win;
    bit         m_busy;
    logic [5:0] m_tok;
    logic [6:0] m_last;
    bit         m_last_vld;
    int         dut_tok;
    bit         prev_valid;
    logic [5:0] rise_tok;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] ref_decode(input logic [6:0] p);
        int top;
`ifdef SEG7_DECODE_HEX_EN
        top = 15;
`else
        top = 9;
`endif
        if (p == 7'h7F) return {4'd0, 1'b1, 1'b0};
        for (int i = 0; i <= top; i++)
            if (pat_tab[i] == p) return {4'(i), 1'b0, 1'b0};
        return {4'd0, 1'b0, 1'b1};
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_hist.push_back(7'h7F);
        m_win      = 1;
        m_busy     = 0;
        m_last     = 7'h00;
        m_last_vld = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic [6:0] l, input logic r);
        bit same;
        m_hist.push_back(l);
        while (m_hist.size() > S + 1) void'(m_hist.pop_front());
        if (m_busy) begin
            if (r) begin
                m_busy = 0;
                m_win  = 1;
            end else begin
                m_win++;
            end
        end else begin
            m_win++;
            same = (m_hist.size() == S + 1);
            foreach (m_hist[i]) if (m_hist[i] != l) same = 0;
            if (m_win >= S + 1 && same && (!m_last_vld || l != m_last)) begin
                m_busy     = 1;
                m_tok      = ref_decode(l);
                m_last     = l;
                m_last_vld = 1;
                exp_q.push_back(m_tok);
            end
        end
    endtask

    task automatic tick();
        logic       xfer;
        logic [5:0] obs_tok;
        xfer    = out_valid && out_ready;
        obs_tok = {bcd, blank, err};
        @(posedge clk);
        model_edge(leds, out_ready);
        if (xfer) begin
            if (exp_q.size() == 0) check("xfer_unexpected", 16'd1, 16'd0);
            else check("xfer_token", 16'(obs_tok), 16'(exp_q.pop_front()));
        end
        @(negedge clk);
        check("valid", 16'(out_valid), 16'(m_busy));
        if (m_busy) check("token", 16'({bcd, blank, err}), 16'(m_tok));
        if (out_valid && !prev_valid) begin
            dut_tok++;
            rise_tok = {bcd, blank, err};
        end
        prev_valid = out_valid;
    endtask

    task automatic hold(input logic [6:0] p, input int n, input logic r);
        leds      = p;
        out_ready = r;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_valid", 16'(out_valid), 16'd0);
        check("rst_bcd", 16'(bcd), 16'd0);
        check("rst_blank", 16'(blank), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        prev_valid = 0;
    endtask

    initial begin
        int         lat;
        logic [6:0] p;
        pat_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        model_reset();
        @(negedge clk);

        // Digit 3 held from reset: latency then a single token.
        leds = pat_tab[3];
        out_ready = 1'b1;
        do_reset();
        dut_tok = 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("t1_latency", 16'(lat), 16'(S + 1));
        check("t1_bcd", 16'(rise_tok), 16'({4'd3, 2'b00}));
        hold(pat_tab[3], 12, 1'b1);
        check("t1_tokens", 16'(dut_tok), 16'd1);

        // Short-lived 5 is filtered, 1 emits once.
        dut_tok = 0;
        hold(pat_tab[5], S - 1, 1'b1);
        hold(pat_tab[1], 12, 1'b1);
        check("t2_tokens", 16'(dut_tok), 16'd1);
        check("t2_bcd", 16'(rise_tok), 16'({4'd1, 2'b00}));

        // Stall with leds toggling, then a one-cycle transfer.
        dut_tok = 0;
        hold(pat_tab[0], 8, 1'b0);
        check("t3_valid_stall", 16'(out_valid), 16'd1);
        repeat (10) hold(7'($urandom_range(0, 127)), 1, 1'b0);
        check("t3_bcd_stall", 16'({bcd, blank, err}), 16'({4'd0, 2'b00}));
        hold(pat_tab[0], 1, 1'b1);
        check("t3_valid_after", 16'(out_valid), 16'd0);
        hold(pat_tab[0], 10, 1'b1);
        check("t3_tokens", 16'(dut_tok), 16'd1);

        // 7, blank, 7: blank in between re-enables the repeated digit.
        dut_tok = 0;
        hold(pat_tab[7], 8, 1'b1);
        hold(7'h7F, 8, 1'b1);
        check("t4_blank", 16'(rise_tok), 16'({4'd0, 2'b10}));
        hold(pat_tab[7], 8, 1'b1);
        check("t4_tokens", 16'(dut_tok), 16'd3);
        check("t4_bcd", 16'(rise_tok), 16'({4'd7, 2'b00}));

        // Hex A: build dependent result.
        hold(pat_tab[10], 8, 1'b1);
`ifdef SEG7_DECODE_HEX_EN
        check("t5_hex_a", 16'(rise_tok), 16'({4'd10, 2'b00}));
`else
        check("t5_hex_a", 16'(rise_tok), 16'({4'd0, 2'b01}));
`endif

        // Reset while a 9 token is pending; 9 is emitted again afterwards.
        hold(pat_tab[9], 8, 1'b0);
        check("t6_pending", 16'({out_valid, bcd}), 16'({1'b1, 4'd9}));
        do_reset();
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("t6_latency", 16'(lat), 16'(S + 1));
        check("t6_bcd", 16'(rise_tok), 16'({4'd9, 2'b00}));
        hold(pat_tab[9], 1, 1'b1);

        // Random patterns, hold lengths and ready.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       p = 7'h7F;
                1:       p = 7'($urandom_range(0, 127));
                default: p = pat_tab[$urandom_range(0, 15)];
            endcase
            leds = p;
            repeat ($urandom_range(1, 8)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        hold(leds, 12, 1'b1);
        check("final_queue_empty", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
